// File: rtl/cconv_pkg.sv
// Shared types and constants for the circular-convolution sequencer and datapath.
package cconv_pkg;

    localparam int unsigned N_DEF = 10;
    localparam int unsigned W_DEF = 32;

    localparam logic MODE_LOAD = 1'b1;
    localparam logic MODE_ROT  = 1'b0;

    typedef enum logic [2:0] {IDLE, CLR, LOADH, LOADX, CALC, DONE} state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cconv_idx_cnt.sv
// Clearable, enabled beat index with a terminal flag at N-1.
module cconv_idx_cnt
    import cconv_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic enb,
    output logic last
);

    localparam int unsigned IW = idx_width(N);

    logic [IW-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (enb) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == IW'(N - 1));

endmodule

// File: rtl/cconv_seq.sv
// Sequencer for the circular-convolution datapath: loads an N-sample block,
// then streams N results, one per rotation.
module cconv_seq
    import cconv_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   coef_sel,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] x,
    output logic         shift_r,
    output logic         mode_r,
    output logic         reset_r,
    output logic [1:0]   sel_h,
    output logic         ce_h,
    output logic         reset_h,
    output logic         reset_c,
    output logic         count_enb,
    input  logic [W-1:0] y_in,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    state_t     state;
    logic [1:0] sel_q;
    logic       in_beat;
    logic       out_beat;
    logic       idx_last;
    logic       idx_clr;

    assign in_beat  = (state == LOADX) && in_valid;
    assign out_beat = (state == CALC) && out_ready;
    // Index restarts for the rotate phase once the N-th sample has gone in.
    assign idx_clr  = (state == CLR) || (in_beat && idx_last);

    cconv_idx_cnt #(.N(N)) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (idx_clr),
        .enb   (in_beat || out_beat),
        .last  (idx_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q <= coef_sel;
                        state <= CLR;
                    end
                end
                CLR:   state <= LOADH;
                LOADH: state <= LOADX;
                LOADX: if (in_beat && idx_last) state <= CALC;
                CALC:  if (out_beat && idx_last) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Mealy decode: strobes follow the handshake so the datapath moves on the accepting edge.
    always_comb begin
        shift_r   = in_beat || out_beat;
        mode_r    = in_beat ? MODE_LOAD : MODE_ROT;
        count_enb = in_beat || out_beat;
        in_ready  = (state == LOADX);
        x         = (state == LOADX) ? in_data : '0;
        out_valid = (state == CALC);
        out_data  = (state == CALC) ? y_in : '0;
        reset_r   = (state == CLR);
        reset_c   = (state == CLR);
        ce_h      = (state == LOADH);
        sel_h     = sel_q;
        reset_h   = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_cconv_seq.sv
// Scoreboard bench for cconv_seq with a behavioural rotator/coefficient/MAC/counter datapath.
module tb_cconv_seq;

    localparam int N = 10;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   coef_sel = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, shift_r, mode_r, reset_r, ce_h, reset_h, reset_c, count_enb;
    logic         out_valid, busy, done;
    logic [1:0]   sel_h;
    logic [W-1:0] x, y_in, out_data;

    always #5 clk = ~clk;

    cconv_seq #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .coef_sel(coef_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .x(x), .shift_r(shift_r), .mode_r(mode_r), .reset_r(reset_r),
        .sel_h(sel_h), .ce_h(ce_h), .reset_h(reset_h), .reset_c(reset_c),
        .count_enb(count_enb), .y_in(y_in), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
    );

    // Datapath model: rotator (shift-in at [0]), coefficient bank, MAC, beat counter.
    logic [W-1:0] rot [N];
    logic [1:0]   hsel = '0;
    logic [W-1:0] cnt = '0;

    function automatic logic [W-1:0] coef(input logic [1:0] s, input int j);
        case (s)
            2'd0:    return (j == 0) ? 32'd1 : 32'd0;
            2'd1:    return (j == 1) ? 32'd1 : 32'd0;
            2'd2:    return (j == 0) ? 32'd1 : ((j == 1) ? 32'd2 : 32'd0);
            default: return (j == 0) ? 32'd3 : 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_r) begin
            for (int i = 0; i < N; i++) rot[i] <= '0;
        end else if (shift_r) begin
            rot[0] <= mode_r ? x : rot[N-1];
            for (int i = 1; i < N; i++) rot[i] <= rot[i-1];
        end
        if (reset_h) hsel <= '0;
        else if (ce_h) hsel <= sel_h;
        if (reset_c) cnt <= '0;
        else if (count_enb) cnt <= cnt + 1;
    end

    always_comb begin
        y_in = '0;
        for (int j = 0; j < N; j++) y_in = y_in + coef(hsel, j) * rot[j];
    end

    // Hand-computed results for samples 1..10, per coefficient set, k = 0..9.
    int tab [4][10] = '{
        '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9},
        '{ 9, 10, 1, 2, 3, 4, 5, 6, 7, 8},
        '{28, 21, 4, 7, 10, 13, 16, 19, 22, 25},
        '{30, 3, 6, 9, 12, 15, 18, 21, 24, 27}
    };

    logic [127:0] outs;
    assign outs = {x, shift_r, mode_r, reset_r, sel_h, ce_h, reset_h, reset_c,
                   count_enb, in_ready, out_valid, out_data, busy, done};

    int checks = 0;
    int errors = 0;
    int exp_q [$];
    int done_q [$];
    int cyc = 0;
    int start_cyc = 0;
    int in_beats = 0;
    int out_beats = 0;
    int done_cnt = 0;
    int job_sel = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no matching event at %0t", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations when the DUT presents results or ends a job.
    initial begin
        bit           hold_p;
        bit           in_b, out_b;
        logic [W-1:0] held;
        int           e;
        hold_p = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_p = 1'b0;
            end else begin
                if (start && !busy) begin
                    in_beats = 0;
                    out_beats = 0;
                    start_cyc = cyc;
                end
                if (busy) chk("sel_h", sel_h, job_sel);
                if (reset_r) begin
                    chk("clr_cycle", cyc - start_cyc, 1);
                    chk("clr_reset_c", reset_c, 1);
                end
                if (ce_h) begin
                    chk("loadh_cycle", cyc - start_cyc, 2);
                    chk("reset_h", reset_h, 0);
                end
                in_b  = in_valid && in_ready;
                out_b = out_valid && out_ready;
                if (in_ready) chk("in_ready_after_n", in_beats < N, 1);
                if (in_b) begin
                    chk("x", x, in_data);
                    chk("load_strobes", {shift_r, mode_r, count_enb}, 3'b111);
                    in_beats++;
                end else if (!in_ready) begin
                    chk("x_zero", x, 0);
                end
                if (out_valid) begin
                    if (hold_p) chk("held_data", out_data, held);
                    if (out_ready) begin
                        if (exp_q.size() == 0) fail("unexpected_result");
                        else begin
                            e = exp_q.pop_front();
                            chk("result", out_data, e);
                        end
                        chk("rot_strobes", {shift_r, mode_r, count_enb}, 3'b101);
                        out_beats++;
                        hold_p = 1'b0;
                    end else begin
                        hold_p = 1'b1;
                        held = out_data;
                    end
                end
                if (!in_b && !out_b) chk("no_shift", {shift_r, count_enb}, 0);
                if (done) begin
                    if (done_q.size() == 0) fail("unexpected_done");
                    else begin
                        e = done_q.pop_front();
                        if (e >= 0) chk("done_cycle", cyc - start_cyc, e);
                    end
                    chk("counter", cnt, 2 * N);
                    chk("in_beats", in_beats, N);
                    chk("out_beats", out_beats, N);
                    done_cnt++;
                end
            end
        end
    end

    task automatic run_job(input int sel, input bit bubbles, input int stall_at,
                           input bit mid_start, input int reset_at, input int lat);
        int sent, t, stalled, d0;
        @(posedge clk); #1;
        job_sel = sel;
        for (int k = 0; k < N; k++) exp_q.push_back(tab[sel][k]);
        if (reset_at < 0) done_q.push_back(lat);
        d0 = done_cnt;
        start = 1'b1;
        coef_sel = 2'(sel);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0;
        t = 0;
        while (sent < N && t < 200) begin
            in_valid = bubbles ? ((t % 2) == 0) : 1'b1;
            in_data = W'(sent + 1);
            if (mid_start && sent == 4) begin
                start = 1'b1;
                coef_sel = 2'd0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            start = 1'b0;
            coef_sel = 2'(sel);
            t++;
        end
        in_valid = 1'b0;
        if (sent < N) fail("load_timeout");
        stalled = 0;
        t = 0;
        while (out_beats < N && t < 200) begin
            if (reset_at >= 0 && out_beats == reset_at) begin
                reset = 1'b1;
                #1;
                chk("reset_mid_outs", outs, 0);
                exp_q.delete();
                done_q.delete();
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (stall_at >= 0 && out_beats == stall_at && stalled < 3) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
        if (out_beats < N) fail("result_timeout");
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == d0) fail("done_timeout");
        if (exp_q.size() != 0) fail("results_left");
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_reset_outs", outs, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_outs", outs, 0);
        end
        run_job(2, 1'b0, -1, 1'b0, -1, 23);
        run_job(0, 1'b0,  4, 1'b0, -1, -1);
        run_job(3, 1'b1, -1, 1'b1, -1, -1);
        run_job(1, 1'b0, -1, 1'b0,  5, -1);
        @(negedge clk);
        chk("post_reset_outs", outs, 0);
        run_job(1, 1'b0, -1, 1'b0, -1, 23);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
